// File: rtl/conv_req_sched_if.sv
// conv_req_sched_if -- bus bundle for the converter request scheduler.
//   req_*  : tagged request stream into the scheduler (valid/ready)
//   cv_*   : command/result wires between scheduler and unit converter
//   rsp_*  : tagged response stream out of the scheduler (valid/ready)
//   busy   : scheduler has queued or in-flight work
// slave  = scheduler side, master = environment side (requester, converter
// and response consumer).
interface conv_req_sched_if #(
  parameter int TAG_W = 4
);
  logic             req_valid;
  logic             req_ready;
  logic [31:0]      req_number;
  logic [1:0]       req_type;
  logic [2:0]       req_select;
  logic             req_reverse;
  logic [TAG_W-1:0] req_tag;

  logic [31:0]      cv_number_in;
  logic             cv_valid_in;
  logic [1:0]       cv_type;
  logic [2:0]       cv_select;
  logic             cv_reverse;
  logic [31:0]      cv_number_out;
  logic             cv_valid_out;

  logic             rsp_valid;
  logic             rsp_ready;
  logic [31:0]      rsp_number;
  logic [TAG_W-1:0] rsp_tag;
  logic             rsp_error;

  logic             busy;

  modport slave (
    input  req_valid, req_number, req_type, req_select, req_reverse, req_tag,
    input  cv_number_out, cv_valid_out, rsp_ready,
    output req_ready, cv_number_in, cv_valid_in, cv_type, cv_select, cv_reverse,
    output rsp_valid, rsp_number, rsp_tag, rsp_error, busy
  );

  modport master (
    output req_valid, req_number, req_type, req_select, req_reverse, req_tag,
    output cv_number_out, cv_valid_out, rsp_ready,
    input  req_ready, cv_number_in, cv_valid_in, cv_type, cv_select, cv_reverse,
    input  rsp_valid, rsp_number, rsp_tag, rsp_error, busy
  );
endinterface

// File: rtl/conv_req_sched.sv
// conv_req_sched -- queues tagged conversion requests and feeds them to the
// unit converter one at a time, returning each result with its tag.
//   clk : rising-edge clock
//   rst : synchronous active-low reset
//   bus : conv_req_sched_if.slave (request in, converter command/result,
//         response out, busy)
// Parameters: DEPTH request FIFO entries (power of 2, >=2), TAG_W tag width
// (must match the interface), TIMEOUT max converter wait (>=2).
module conv_req_sched #(
  parameter int DEPTH   = 4,
  parameter int TAG_W   = 4,
  parameter int TIMEOUT = 64
) (
  input  logic            clk,
  input  logic            rst,
  conv_req_sched_if.slave bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(TIMEOUT) + 1;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SETUP = 3'd1;
  localparam logic [2:0] S_ISSUE = 3'd2;
  localparam logic [2:0] S_WAIT  = 3'd3;
  localparam logic [2:0] S_RESP  = 3'd4;

  typedef struct packed {
    logic [31:0]      number;
    logic [1:0]       ctype;
    logic [2:0]       sel;
    logic             rev;
    logic [TAG_W-1:0] tag;
  } cmd_t;

  cmd_t             mem [DEPTH];
  cmd_t             req_in;
  cmd_t             cmd;
  logic [PW-1:0]    wr_ptr, rd_ptr;
  logic [PW:0]      count, count_nxt;
  logic             req_ready_q;
  logic [2:0]       state;
  logic [CW-1:0]    tmo_cnt, tmo_inc;
  logic [31:0]      rsp_number_q;
  logic [TAG_W-1:0] rsp_tag_q;
  logic             rsp_error_q;
  logic             push, pop;

  assign req_in = '{number: bus.req_number, ctype: bus.req_type,
                    sel: bus.req_select, rev: bus.req_reverse, tag: bus.req_tag};

  // req_ready is a register, so a full FIFO refuses a push even when the
  // head is popped in the same cycle.
  assign push    = bus.req_valid & req_ready_q;
  assign pop     = (state == S_IDLE) && (count != '0);
  assign tmo_inc = tmo_cnt + CW'(1);

  always_comb begin
    count_nxt = count + {{PW{1'b0}}, push} - {{PW{1'b0}}, pop};
  end

  // Storage is not reset; occupancy is tracked by count alone.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= req_in;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_ptr       <= '0;
      rd_ptr       <= '0;
      count        <= '0;
      req_ready_q  <= 1'b1;
      state        <= S_IDLE;
      cmd          <= '0;
      tmo_cnt      <= '0;
      rsp_number_q <= '0;
      rsp_tag_q    <= '0;
      rsp_error_q  <= 1'b0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      count       <= count_nxt;
      req_ready_q <= (count_nxt != (PW+1)'(DEPTH));
      case (state)
        S_IDLE: begin
          // cmd drives the cv_* wires directly, so they change only here
          if (pop) begin
            cmd   <= mem[rd_ptr];
            state <= S_SETUP;
          end
        end
        // one settle cycle with the new command visible before the strobe
        S_SETUP: state <= S_ISSUE;
        S_ISSUE: begin
          tmo_cnt <= '0;
          state   <= S_WAIT;
        end
        S_WAIT: begin
          if (bus.cv_valid_out) begin
            rsp_number_q <= bus.cv_number_out;
            rsp_tag_q    <= cmd.tag;
            rsp_error_q  <= 1'b0;
            state        <= S_RESP;
          end else if (tmo_inc == CW'(TIMEOUT - 1)) begin
            // response lands exactly TIMEOUT cycles after ISSUE
            rsp_number_q <= 32'h7FC0_0000;
            rsp_tag_q    <= cmd.tag;
            rsp_error_q  <= 1'b1;
            state        <= S_RESP;
          end else begin
            tmo_cnt <= tmo_inc;
          end
        end
        S_RESP: if (bus.rsp_ready) state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.req_ready    = req_ready_q;
  assign bus.cv_number_in = cmd.number;
  assign bus.cv_type      = cmd.ctype;
  assign bus.cv_select    = cmd.sel;
  assign bus.cv_reverse   = cmd.rev;
  assign bus.cv_valid_in  = (state == S_ISSUE);
  assign bus.rsp_valid    = (state == S_RESP);
  assign bus.rsp_number   = rsp_number_q;
  assign bus.rsp_tag      = rsp_tag_q;
  assign bus.rsp_error    = rsp_error_q;
  assign bus.busy         = (state != S_IDLE) || (count != '0);
endmodule

// File: doc/conv_req_sched.md
Name: conv_req_sched

Overview:
- Request scheduler that sits directly upstream of the unit converter.
- Accepts tagged conversion requests over a valid/ready interface and buffers them in a small FIFO.
- Issues one request at a time to the converter, holding type/select/reverse stable for the whole conversion.
- Returns each result with its tag over a valid/ready response port, with a timeout guard for a stalled converter.

Parameters:
DEPTH, 4, request FIFO entries (power of 2, >=2)
TAG_W, 4, request tag width
TIMEOUT, 64, max cycles in WAIT before an error response

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-low reset
req_valid  in  1  request present
req_ready  out  1  request FIFO not full
req_number  in  32  IEEE-754 single operand
req_type  in  2  conversion type (0 length, 1 mass, 2 volume, 3 temperature)
req_select  in  3  sub-conversion select
req_reverse  in  1  conversion direction
req_tag  in  TAG_W  request tag
cv_number_in  out  32  to converter number_in
cv_valid_in  out  1  to converter valid_in, one-cycle pulse
cv_type  out  2  to converter type
cv_select  out  3  to converter select
cv_reverse  out  1  to converter reverse
cv_number_out  in  32  from converter number_out
cv_valid_out  in  1  from converter valid_out
rsp_valid  out  1  response present
rsp_ready  in  1  response accepted
rsp_number  out  32  result
rsp_tag  out  TAG_W  tag of the originating request
rsp_error  out  1  1 = timeout; rsp_number = 32'h7FC00000
busy  out  1  FSM not in IDLE or FIFO non-empty

Behaviour:
- Reset (rst=0 at a clock edge):
  - FIFO emptied, FSM to IDLE.
  - All outputs 0, except req_ready=1 once rst=1.
  - Reset mid-operation drops in-flight and queued requests; no response is produced for them.
- FIFO:
  - Push when req_valid & req_ready.
  - req_ready = !full, registered from the count. Full means no push even if a pop occurs in the same cycle (no bypass).
  - Push and pop in the same cycle are legal when not full; count is unchanged.
  - Pointers are log2(DEPTH) bits, wrap naturally; count is log2(DEPTH)+1 bits.
- FSM states IDLE, SETUP, ISSUE, WAIT, RESP:
  - IDLE: if FIFO non-empty, pop head into command registers -> SETUP. Else stay.
  - SETUP (1 cycle): cv_type/cv_select/cv_reverse/cv_number_in driven from command registers; cv_valid_in=0. This lets the converter's negedge factor update settle. -> ISSUE.
  - ISSUE (1 cycle): cv_valid_in=1. -> WAIT, timeout counter cleared.
  - WAIT: cv_valid_out=1 -> capture cv_number_out into rsp_number, rsp_tag=command tag, rsp_error=0 -> RESP. Otherwise the counter increments; on reaching TIMEOUT-1 -> RESP with rsp_number=32'h7FC00000, rsp_error=1.
  - RESP: rsp_valid=1, rsp_number/rsp_tag/rsp_error held stable. rsp_ready=1 -> IDLE, rsp_valid=0 next cycle.
- cv_type/cv_select/cv_reverse/cv_number_in hold their values from SETUP until the next SETUP; they never change during WAIT.
- cv_valid_out outside WAIT is ignored, including a late result after a timeout.
- Latency: request accepted at cycle 0 into an empty FIFO.
  - IDLE pop at cycle 1, SETUP at cycle 2, ISSUE at cycle 3.
  - rsp_valid asserts the cycle after cv_valid_out is seen.
  - Minimum request-to-request issue spacing is 4 cycles + converter latency.
- Responses are returned in request order; only one request is outstanding at the converter.
- busy=1 whenever state != IDLE or count != 0.

Test Plan:
1. Length, inch->mm: req_number=32'h3F800000, type 0, select 0, reverse 0, tag 5; converter model returns 32'h41CB3333 after 3 cycles.
   -> cv_valid_in a single pulse with cv_type=0/cv_select=0 stable through WAIT; rsp_number=32'h41CB3333, rsp_tag=5, rsp_error=0.
2. Temperature F->C: 32'h43540000 (212.0), type 3, reverse 0.
   -> rsp_number=32'h42C80000 (100.0); reverse=1 with 32'h42C80000 -> 32'h43540000.
3. Burst of 6 back-to-back requests, tags 0..5, rsp_ready=1, converter stalled in WAIT on the first.
   -> req_ready drops after 5 accepted (1 popped + 4 queued); the sixth is held until a pop.
   -> Responses emerge with tags 0..5 in order.
4. rsp_ready held 0 for 10 cycles in RESP.
   -> rsp_valid/number/tag stable; no new cv_valid_in until the handshake completes.
5. Converter never returns cv_valid_out.
   -> Exactly TIMEOUT cycles after ISSUE, rsp_valid=1, rsp_error=1, rsp_number=32'h7FC00000.
   -> A late cv_valid_out while in IDLE produces no response.
6. rst=0 asserted in WAIT with 3 requests queued.
   -> Next cycle: state IDLE, count 0, req_ready=1, rsp_valid=0, busy=0, no responses emitted.
